// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line levels.
package uart_pkg;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Read side of a show-ahead TX FIFO: occupancy flag, top-of-FIFO word and pop strobe.
interface uart_tx_serializer_if #(
    parameter int WIDTH = 8
);
    logic             fifo_not_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read;

    modport master (
        output fifo_not_empty,
        output fifo_data,
        input  fifo_read
    );

    modport slave (
        input  fifo_not_empty,
        input  fifo_data,
        output fifo_read
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick flags the terminal count of the current bit.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sync_reset) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = div;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops the TX FIFO and serializes start/data/[parity]/stop onto txd.
// Parity bit is present only when UART_TX_PARITY_EN is defined (normally set in config.vh).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 tx_enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_odd,
    uart_tx_serializer_if.slave  fifo,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    uart_tx_state_t       state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 txd_q, txd_d;

    logic                 tick;
    logic                 in_frame;
    logic                 bit_end;
    logic                 last_stop;
    logic                 start_frame;
    logic                 frame_end;
    logic                 baud_load;
    logic [DIV_WIDTH-1:0] baud_load_val;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign in_frame  = (state_q != IDLE);
    assign bit_end   = in_frame && tick;
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_q;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .load       (baud_load),
        .div        (baud_load_val),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            div_q   <= '0;
            txd_q   <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            div_q   <= div_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // txd_d is the level for the next cycle, so the pad flop changes on the bit boundary itself.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        div_d   = div_q;
        txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (sync_reset) begin
            state_d = IDLE;
            txd_d   = UART_IDLE_LEVEL;
            bit_d   = '0;
            stop_d  = 1'b0;
        end else if (start_frame) begin
            state_d = START;
            txd_d   = UART_START_LEVEL;
            shift_d = fifo.fifo_data;
            div_d   = baud_div;
            bit_d   = '0;
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^fifo.fifo_data) ^ parity_odd;
`endif
        end else if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = UART_IDLE_LEVEL;
`endif
                    end else begin
                        txd_d = shift_d[0];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                    txd_d   = UART_IDLE_LEVEL;
                end
`endif
                STOP: begin
                    if (last_stop) begin
                        state_d = IDLE;
                        txd_d   = UART_IDLE_LEVEL;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    // A pop in the final stop cycle chains the next frame with no idle gap.
    always_comb begin
        frame_end     = 1'b0;
        start_frame   = 1'b0;
        if (reset_n && !sync_reset) begin
            frame_end   = (state_q == STOP) && tick && last_stop;
            start_frame = tx_enable && fifo.fifo_not_empty &&
                          ((state_q == IDLE) || frame_end);
        end
        baud_load     = start_frame || bit_end;
        baud_load_val = start_frame ? baud_div : div_q;
    end

    assign fifo.fifo_read = start_frame;
    assign tx_done        = frame_end;
    assign tx_busy        = in_frame;
    assign txd            = txd_q;
endmodule
